ifm_row_sender: RTL and testbench

Streams IFM words from the on-chip IFM BRAM toward the conv3 line-buffer path, in the row-pass order consumed by the conv3 row controller (prime pass, single-row reuse passes, BRAM-served last row). One sweep is repeated once per output channel. It issues BRAM reads, absorbs the 1-cycle read latency and output backpressure in a 2-entry skid FIFO, and drives a valid/ready stream whose handshake (`m_valid & m_ready`) is the downstream `temp_hs`.

---
 rtl/ifm_row_sender.sv | 209 ++++++++++++++++++++
 tb/tb_ifm_row_sender.sv | 480 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifm_row_sender.sv
// IFM BRAM reader: row-pass sweep (prime, reuse rows, last row)
// per output channel, with a 2-entry skid FIFO on the stream side.
module ifm_row_sender #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [8:0]        ifm_width,
  input  logic [10:0]       ifm_channel,
  input  logic [10:0]       ofm_channel,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              rowlast_done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_pass_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_ROW,
    S_WAIT
  } state_t;

  state_t state;

  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] base_q;
  logic [10:0]       c_cnt;
  logic [10:0]       c_last;
  logic [4:0]        w_cnt;
  logic [4:0]        w_last;
  logic [8:0]        h_cnt;
  logic [8:0]        h_last;
  logic [10:0]       ofm_cnt;
  logic [10:0]       ofm_last;
  logic              rl_seen;

  logic              width_ok;
  logic [4:0]        w_words;

  logic              inflight;
  logic              inflight_last;
  logic [DATA_W-1:0] fifo_data [2];
  logic [1:0]        fifo_last;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        occ;
  logic [1:0]        fill;

  logic              reading;
  logic              c_end;
  logic              w_end;
  logic              row_end;
  logic              pass_end;
  logic              drained;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head_data;
  logic              head_last;

  always_comb begin
    width_ok = 1'b1;
    w_words  = '0;
    unique case (ifm_width)
      9'd416:  w_words = 5'd31;
      9'd208:  w_words = 5'd15;
      9'd104:  w_words = 5'd7;
      9'd52:   w_words = 5'd3;
      9'd26:   w_words = 5'd1;
      9'd13:   w_words = 5'd0;
      default: width_ok = 1'b0;
    endcase
  end

  assign reading  = (state == S_PRIME) || (state == S_ROW);
  assign fill     = occ + {1'b0, inflight};
  // Count the in-flight read so a stalled stream can never overflow
  assign rd_en    = reading && (fill < 2'd2);
  assign rd_addr  = ptr;

  assign c_end    = (c_cnt == c_last);
  assign w_end    = (w_cnt == w_last);
  assign row_end  = c_end && w_end;
  assign pass_end = row_end &&
                    ((state != S_PRIME) || (h_cnt == 9'd1));
  assign drained  = (occ == 2'd0) && !inflight;

  // Empty FIFO: the returning BRAM word is presented directly
  assign m_valid   = (occ != 2'd0) || inflight;
  assign head_data = (occ != 2'd0) ? fifo_data[rd_ptr] : rd_data;
  assign head_last = (occ != 2'd0) ? fifo_last[rd_ptr] : inflight_last;
  assign m_data    = m_valid ? head_data : '0;
  assign m_pass_last = m_valid && head_last;

  assign pop  = (occ != 2'd0) && m_ready;
  assign push = inflight && !((occ == 2'd0) && m_ready);

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= rd_data;
      fifo_last[wr_ptr] <= inflight_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      occ           <= 2'd0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      occ           <= occ + {1'b0, push} - {1'b0, pop};
      inflight      <= rd_en;
      inflight_last <= rd_en && pass_end;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ptr      <= '0;
      base_q   <= '0;
      c_cnt    <= '0;
      c_last   <= '0;
      w_cnt    <= '0;
      w_last   <= '0;
      h_cnt    <= '0;
      h_last   <= '0;
      ofm_cnt  <= '0;
      ofm_last <= '0;
      rl_seen  <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if ((state != S_IDLE) && rowlast_done) rl_seen <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (width_ok) begin
              base_q   <= base_addr;
              ptr      <= base_addr;
              c_last   <= ifm_channel - 11'd1;
              w_last   <= w_words;
              h_last   <= ifm_width - 9'd1;
              ofm_last <= ofm_channel - 11'd1;
              c_cnt    <= '0;
              w_cnt    <= '0;
              h_cnt    <= '0;
              ofm_cnt  <= '0;
              rl_seen  <= 1'b0;
              state    <= S_PRIME;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_PRIME, S_ROW: begin
          if (rd_en) begin
            ptr   <= ptr + 1'b1;
            c_cnt <= c_end ? '0 : c_cnt + 11'd1;
            if (c_end) w_cnt <= w_end ? '0 : w_cnt + 5'd1;
            if (row_end) begin
              if ((state == S_ROW) && (h_cnt == h_last)) begin
                h_cnt <= '0;
                state <= S_WAIT;
              end else begin
                h_cnt <= h_cnt + 9'd1;
              end
            end
            if (pass_end && (state == S_PRIME)) state <= S_ROW;
          end
        end
        S_WAIT: begin
          if (drained && (rl_seen || rowlast_done)) begin
            rl_seen <= 1'b0;
            if (ofm_cnt == ofm_last) begin
              ofm_cnt <= '0;
              done    <= 1'b1;
              state   <= S_IDLE;
            end else begin
              ofm_cnt <= ofm_cnt + 11'd1;
              ptr     <= base_q;
              state   <= S_PRIME;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifm_row_sender.sv
// Bench for ifm_row_sender: random backpressure against an address-list
// model of the sweep order, with BRAM and consumer models.
module tb_ifm_row_sender;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  ifm_width;
  logic [10:0] ifm_channel;
  logic [10:0] ofm_channel;
  logic [15:0] base_addr;
  logic        rowlast_done;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [63:0] rd_data;
  logic [63:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_pass_last;
  logic        busy;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  ifm_row_sender #(.DATA_W(64), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .ifm_width(ifm_width), .ifm_channel(ifm_channel),
    .ofm_channel(ofm_channel), .base_addr(base_addr),
    .rowlast_done(rowlast_done), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_pass_last(m_pass_last), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_word(input logic [15:0] a);
    return {a ^ 16'h5a3c, a, a * 16'd3 + 16'd1, ~a};
  endfunction

  // BRAM: data only meaningful the cycle after rd_en
  always @(posedge clk)
    rd_data <= rd_en ? mem_word(rd_addr) : {$urandom, $urandom};

  logic [63:0] exp_data[$];
  logic        exp_last[$];
  logic [63:0] obs_data[$];
  logic        obs_last[$];
  int          obs_it[$];
  int          rl_it[$];
  int          lasths_it[$];
  int          done_it, busy_after, extra_done, first_rd_it;
  logic [15:0] first_rd_addr;
  int          rd_viol, stall_viol, timed_out;

  task automatic build_model(input int h, input int c, input int k,
                             input logic [15:0] base);
    int wpr;
    logic [15:0] a;
    wpr = h / 13;
    exp_data.delete();
    exp_last.delete();
    for (int s = 0; s < k; s++)
      for (int r = 0; r < h; r++)
        for (int w = 0; w < wpr; w++)
          for (int ch = 0; ch < c; ch++) begin
            a = base + 16'((r * wpr + w) * c + ch);
            exp_data.push_back(mem_word(a));
            exp_last.push_back(r >= 1 && w == wpr - 1 && ch == c - 1);
          end
  endtask

  function automatic int first_word_diff();
    int n;
    n = (obs_data.size() < exp_data.size()) ? obs_data.size()
                                            : exp_data.size();
    for (int i = 0; i < n; i++)
      if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i])
        return i;
    if (obs_data.size() != exp_data.size()) return n;
    return -1;
  endfunction

  function automatic logic [64:0] obs_at(input int i);
    if (i < 0 || i >= obs_data.size()) return 'x;
    return {obs_last[i], obs_data[i]};
  endfunction

  function automatic logic [64:0] exp_at(input int i);
    if (i < 0 || i >= exp_data.size()) return 'x;
    return {exp_last[i], exp_data[i]};
  endfunction

  // Sweep s ends once drained and rowlast_done seen: the iteration
  // where done (final sweep) or the next PRIME state becomes visible.
  function automatic int exp_exit(input int s);
    int a, b;
    if (s >= rl_it.size() || s >= lasths_it.size()) return -2;
    a = rl_it[s] + 1;
    b = lasths_it[s] + 2;
    return (a > b) ? a : b;
  endfunction

  // rmode: 0 ready high, 1 toggle, 2 random.
  // lmode: 0 rowlast_done gap cycles after sweep drained,
  //        1 rowlast_done 3 words before sweep end.
  task automatic run(input int h, input int c, input int k,
                     input logic [15:0] base, input int rmode,
                     input int lmode, input int gap);
    int total, hs, issued, rl_sent, wcnt, budget;
    logic pstall;
    logic [63:0] pd;
    logic pl;
    total = h * (h / 13) * c;
    hs = 0; issued = 0; rl_sent = 0; wcnt = 0;
    pstall = 1'b0; pd = '0; pl = 1'b0;
    budget = k * (total * 4 + 60) + 100;
    obs_data.delete(); obs_last.delete(); obs_it.delete();
    rl_it.delete(); lasths_it.delete();
    done_it = -1; busy_after = -1; extra_done = -1;
    first_rd_it = -1; first_rd_addr = '0;
    rd_viol = 0; stall_viol = 0; timed_out = 1;
    ifm_width = 9'(h); ifm_channel = 11'(c);
    ofm_channel = 11'(k); base_addr = base;
    for (int it = 0; it < budget; it++) begin
      @(negedge clk);
      start = (it == 0);
      if (it == 1) begin
        ifm_width = 9'($urandom); ifm_channel = 11'($urandom);
        ofm_channel = 11'($urandom); base_addr = 16'($urandom);
      end
      case (rmode)
        0: m_ready = 1'b1;
        1: m_ready = (it % 2 == 0);
        default: m_ready = ($urandom_range(0, 2) != 0);
      endcase
      rowlast_done = 1'b0;
      if (rl_sent < k) begin
        if (lmode == 0) begin
          if (hs >= total * (rl_sent + 1)) begin
            wcnt++;
            if (wcnt >= gap) begin
              rowlast_done = 1'b1;
              wcnt = 0;
            end
          end
        end else if (hs == total * (rl_sent + 1) - 3) begin
          rowlast_done = 1'b1;
        end
        if (rowlast_done) begin
          rl_it.push_back(it);
          rl_sent++;
        end
      end
      if (rd_en) begin
        if (first_rd_it < 0) begin
          first_rd_it = it;
          first_rd_addr = rd_addr;
        end
        if (issued - hs >= 2) rd_viol++;
        issued++;
      end
      if (pstall && (!m_valid || m_data !== pd || m_pass_last !== pl))
        stall_viol++;
      pstall = m_valid && !m_ready;
      pd = m_data;
      pl = m_pass_last;
      if (m_valid && m_ready) begin
        obs_data.push_back(m_data);
        obs_last.push_back(m_pass_last);
        obs_it.push_back(it);
        hs++;
        if (hs % total == 0) lasths_it.push_back(it);
      end
      if (done_it >= 0) begin
        busy_after = int'(busy);
        extra_done = int'(done);
        timed_out = 0;
        break;
      end
      if (done) done_it = it;
    end
    start = 1'b0;
    rowlast_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rowlast_done = 1'b0; m_ready = 1'b0;
    ifm_width = '0; ifm_channel = '0; ofm_channel = '0; base_addr = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({rd_en, rd_addr, m_valid, m_data, m_pass_last, busy, done, err}
        !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rd_en=%b addr=%h v=%b d=%h pl=%b busy=%b done=%b err=%b want all 0",
               rd_en, rd_addr, m_valid, m_data, m_pass_last, busy, done, err);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({rd_en, m_valid, busy, done, err} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_idle: got rd_en=%b v=%b busy=%b done=%b err=%b want 0",
               rd_en, m_valid, busy, done, err);
    end
  endtask

  task automatic test_basic();
    int d, e;
    build_model(13, 2, 1, 16'h0100);
    run(13, 2, 1, 16'h0100, 0, 0, 3);
    n_cmp++;
    if (timed_out !== 0) begin
      n_bad++;
      $display("FAIL basic_timeout: done_it=%0d want done seen", done_it);
    end
    d = first_word_diff();
    n_cmp++;
    if (d != -1) begin
      n_bad++;
      $display("FAIL basic_words: word %0d got %h want %h (%0d vs %0d words)",
               d, obs_at(d), exp_at(d), obs_data.size(), exp_data.size());
    end
    n_cmp++;
    if (first_rd_it != 1 || first_rd_addr !== 16'h0100) begin
      n_bad++;
      $display("FAIL basic_first_rd: got it=%0d addr=%h want it=1 addr=0100",
               first_rd_it, first_rd_addr);
    end
    n_cmp++;
    if (obs_it.size() != 26 || obs_it[0] != 2 || obs_it[25] != 27) begin
      n_bad++;
      $display("FAIL basic_timing: got %0d words first=%0d last=%0d want 26 2 27",
               obs_it.size(), obs_it.size() ? obs_it[0] : -1,
               obs_it.size() ? obs_it[obs_it.size()-1] : -1);
    end
    e = exp_exit(0);
    n_cmp++;
    if (done_it != e) begin
      n_bad++;
      $display("FAIL basic_done: got it=%0d want %0d", done_it, e);
    end
    n_cmp++;
    if (busy_after != 0 || extra_done != 0) begin
      n_bad++;
      $display("FAIL basic_after_done: got busy=%0d done=%0d want 0 0",
               busy_after, extra_done);
    end
    n_cmp++;
    if (rd_viol != 0) begin
      n_bad++;
      $display("FAIL basic_rd_throttle: got %0d violations want 0", rd_viol);
    end
  endtask

  task automatic test_multi_sweep();
    int d, e0, e1;
    logic [15:0] b;
    b = 16'($urandom);
    build_model(26, 3, 2, b);
    run(26, 3, 2, b, 0, 0, $urandom_range(1, 6));
    d = first_word_diff();
    n_cmp++;
    if (d != -1) begin
      n_bad++;
      $display("FAIL multi_words: word %0d got %h want %h (%0d vs %0d words)",
               d, obs_at(d), exp_at(d), obs_data.size(), exp_data.size());
    end
    e0 = exp_exit(0);
    e1 = exp_exit(1);
    n_cmp++;
    if (obs_it.size() != 312 || obs_it[155] - obs_it[0] != 155 ||
        obs_it[156] != e0 + 1) begin
      n_bad++;
      $display("FAIL multi_timing: got %0d words span=%0d sweep2_at=%0d want 312 155 %0d",
               obs_it.size(),
               obs_it.size() > 155 ? obs_it[155] - obs_it[0] : -1,
               obs_it.size() > 156 ? obs_it[156] : -1, e0 + 1);
    end
    n_cmp++;
    if (done_it != e1 || timed_out !== 0) begin
      n_bad++;
      $display("FAIL multi_done: got it=%0d want %0d", done_it, e1);
    end
  endtask

  task automatic test_stall();
    int d, e;
    for (int m = 1; m <= 2; m++) begin
      build_model(13, 4, m, 16'h0400 * m);
      run(13, 4, m, 16'h0400 * 16'(m), m, 0, 2);
      d = first_word_diff();
      n_cmp++;
      if (d != -1) begin
        n_bad++;
        $display("FAIL stall%0d_words: word %0d got %h want %h (%0d vs %0d words)",
                 m, d, obs_at(d), exp_at(d), obs_data.size(), exp_data.size());
      end
      n_cmp++;
      if (stall_viol != 0) begin
        n_bad++;
        $display("FAIL stall%0d_hold: got %0d unstable stalls want 0",
                 m, stall_viol);
      end
      n_cmp++;
      if (rd_viol != 0) begin
        n_bad++;
        $display("FAIL stall%0d_rd_throttle: got %0d want 0", m, rd_viol);
      end
      e = exp_exit(m - 1);
      n_cmp++;
      if (done_it != e) begin
        n_bad++;
        $display("FAIL stall%0d_done: got it=%0d want %0d", m, done_it, e);
      end
    end
  endtask

  task automatic test_early_rowlast();
    int d, e;
    build_model(13, 4, 2, 16'h1234);
    run(13, 4, 2, 16'h1234, 2, 1, 1);
    d = first_word_diff();
    n_cmp++;
    if (d != -1) begin
      n_bad++;
      $display("FAIL early_words: word %0d got %h want %h (%0d vs %0d words)",
               d, obs_at(d), exp_at(d), obs_data.size(), exp_data.size());
    end
    e = (lasths_it.size() == 2) ? lasths_it[1] + 2 : -2;
    n_cmp++;
    if (done_it != e) begin
      n_bad++;
      $display("FAIL early_done: got it=%0d want %0d", done_it, e);
    end
  endtask

  task automatic test_illegal();
    int busy_cnt, rd_cnt;
    logic err1, err2;
    busy_cnt = 0; rd_cnt = 0; err1 = 1'b0; err2 = 1'b0;
    ifm_width = 9'd100; ifm_channel = 11'd4; ofm_channel = 11'd1;
    for (int it = 0; it < 12; it++) begin
      @(negedge clk);
      start = (it == 0);
      if (it == 1) err1 = err;
      if (it == 2) err2 = err;
      if (busy) busy_cnt++;
      if (rd_en) rd_cnt++;
    end
    start = 1'b0;
    n_cmp++;
    if (err1 !== 1'b1 || err2 !== 1'b0) begin
      n_bad++;
      $display("FAIL illegal_err: got %b%b want 10", err1, err2);
    end
    n_cmp++;
    if (busy_cnt != 0 || rd_cnt != 0) begin
      n_bad++;
      $display("FAIL illegal_idle: got busy=%0d rd=%0d cycles want 0 0",
               busy_cnt, rd_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int d;
    logic v_before;
    ifm_width = 9'd26; ifm_channel = 11'd3; ofm_channel = 11'd1;
    base_addr = 16'h2222; m_ready = 1'b0;
    for (int it = 0; it < 6; it++) begin
      @(negedge clk);
      start = (it == 0);
    end
    start = 1'b0;
    v_before = m_valid;
    n_cmp++;
    if (v_before !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_pre: got valid=%b busy=%b want 1 1",
               v_before, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({rd_en, rd_addr, m_valid, m_data, m_pass_last, busy, done, err}
        !== '0) begin
      n_bad++;
      $display("FAIL midrst_outputs: got rd_en=%b addr=%h v=%b d=%h pl=%b busy=%b want all 0",
               rd_en, rd_addr, m_valid, m_data, m_pass_last, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    build_model(13, 2, 1, 16'h3000);
    run(13, 2, 1, 16'h3000, 0, 0, 1);
    d = first_word_diff();
    n_cmp++;
    if (d != -1 || first_rd_addr !== 16'h3000 || first_rd_it != 1) begin
      n_bad++;
      $display("FAIL midrst_restart: diff=%0d rd_addr=%h rd_it=%0d want -1 3000 1",
               d, first_rd_addr, first_rd_it);
    end
  endtask

  task automatic test_random();
    int hl[3] = '{13, 26, 52};
    int h, c, k, d, e;
    logic [15:0] b;
    for (int n = 0; n < 4; n++) begin
      h = hl[$urandom_range(0, 2)];
      c = $urandom_range(1, 5);
      k = $urandom_range(1, 2);
      b = (n == 0) ? 16'hfff0 : 16'($urandom);
      build_model(h, c, k, b);
      run(h, c, k, b, 2, $urandom_range(0, 1), $urandom_range(1, 4));
      d = first_word_diff();
      n_cmp++;
      if (d != -1) begin
        n_bad++;
        $display("FAIL rand%0d_words (H=%0d C=%0d K=%0d): word %0d got %h want %h",
                 n, h, c, k, d, obs_at(d), exp_at(d));
      end
      n_cmp++;
      if (rd_viol != 0 || stall_viol != 0) begin
        n_bad++;
        $display("FAIL rand%0d_flow: got rd=%0d stall=%0d want 0 0",
                 n, rd_viol, stall_viol);
      end
      e = exp_exit(k - 1);
      n_cmp++;
      if (done_it != e) begin
        n_bad++;
        $display("FAIL rand%0d_done: got it=%0d want %0d", n, done_it, e);
      end
    end
  endtask

  task automatic test_wide();
    int d, n;
    build_model(416, 1, 1, 16'h0010);
    run(416, 1, 1, 16'h0010, 0, 0, 2);
    d = first_word_diff();
    n = obs_it.size();
    n_cmp++;
    if (d != -1) begin
      n_bad++;
      $display("FAIL wide_words: word %0d got %h want %h (%0d vs %0d words)",
               d, obs_at(d), exp_at(d), obs_data.size(), exp_data.size());
    end
    n_cmp++;
    if (n != 13312 || obs_it[n-1] - obs_it[0] != 13311) begin
      n_bad++;
      $display("FAIL wide_bubbles: got %0d words span %0d want 13312 13311",
               n, n ? obs_it[n-1] - obs_it[0] : -1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_multi_sweep();
    test_stall();
    test_early_rowlast();
    test_illegal();
    test_reset_mid();
    test_random();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
